jk_mod_counter: RTL

//  - Synchronous mod-N up/down counter built from JK flip-flop cells; consumes

---
 rtl/jk_mod_counter.sv | 107 ++++++++++
 1 files changed

// File: rtl/jk_mod_counter.sv
// jk_mod_counter: synchronous mod-MODULUS up/down counter built from JK cells.
// Each bit is a JK flip-flop with J=K=toggle, so a set toggle bit flips the
// cell and a clear one holds it. A load bypasses the JK excitation and
// forces the next state directly. The count is clamped below MODULUS.
//
// Parameters:
//   WIDTH      count width in bits (1..16)
//   MODULUS    count range 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
//
// Ports:
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset
//   enable      count one step this cycle
//   up          1 = count up, 0 = count down
//   load        synchronous load of load_value (priority over enable)
//   load_value  value to load, clamped to MODULUS-1
//   count       registered count (q of the JK cells)
//   count_bar   bitwise complement of count (qbar of the JK cells)
//   wrap        registered one-cycle pulse when the count wraps
//
// Configuration macro:
//   JK_CNT_SATURATE_EN  when defined, the count stops at 0 and MODULUS-1
//                       instead of wrapping. wrap then pulses on every
//                       enabled edge that tries to pass a limit.
module jk_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_bar,
    output logic             wrap
);

    // Comparisons run in WIDTH+1 bits so that MODULUS == 2**WIDTH still fits.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_V = MAX_W[WIDTH-1:0];

    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] jk_next;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] count_next;
    logic             at_max;
    logic             at_zero;
    logic             limit;
    logic             chain;
    logic             wrap_next;

    // Toggle derivation. Away from the limit, bit i toggles when all lower bits
    // are 1 (up) or all are 0 (down). At the limit, the toggle pattern is the
    // XOR of the current count and the wrap target. The JK cells then land
    // exactly on 0 (up) or MODULUS-1 (down).
    always_comb begin
        at_max  = ({1'b0, count} == MAX_W);
        at_zero = (count == '0);
        limit   = up ? at_max : at_zero;
        toggle  = '0;
        chain   = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (up) begin
                toggle[i] = at_max ? count[i] : chain;
                chain     = chain & count[i];
            end else begin
                toggle[i] = at_zero ? (count[i] ^ MAX_V[i]) : chain;
                chain     = chain & count_bar[i];
            end
        end
`ifdef JK_CNT_SATURATE_EN
        if (limit) begin
            toggle = '0;
        end
`endif
        // JK excitation with J=K=toggle: q+ = J&~q | ~K&q
        jk_next = (toggle & ~count) | (~toggle & count);
    end

    always_comb begin
        load_clamped = ({1'b0, load_value} < MOD_W) ? load_value : MAX_V;
        count_next   = count;
        wrap_next    = 1'b0;
        if (load) begin
            count_next = load_clamped;
        end else if (enable) begin
            count_next = jk_next;
            wrap_next  = limit;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_next;
            wrap  <= wrap_next;
        end
    end

    assign count_bar = ~count;

endmodule
